// File: rtl/fsm_byte_sched.sv
// ---------------------------------------------------------------------------
// fsm_byte_sched
//
// Byte-serial scheduler around a 5-state Moore sequence detector.
// A byte is accepted on a valid/ready handshake, its bits are fed to the
// detector LSB first (one bit per clock), and the detector output z after
// every bit is collected into a mask plus a population count. The result is
// then presented on a valid/ready output until the consumer takes it.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-high reset
//   in_valid    producer offers in_data
//   in_ready    high only while idle (a new byte can be taken)
//   in_data     W-bit byte, applied to the detector LSB first
//   in_clr      at accept: restart the detector from state A
//   out_valid   result available (held until out_ready)
//   out_ready   consumer takes the result
//   out_zmask   bit i = detector z after bit i was applied
//   out_zcount  number of ones in out_zmask
//   fsm_state   current detector state encoding (debug)
// ---------------------------------------------------------------------------
module fsm_byte_sched #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_zmask,
    output logic [CW-1:0] out_zcount,
    output logic [2:0]    fsm_state
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {
        CTL_IDLE   = 2'b00,
        CTL_SHIFT  = 2'b01,
        CTL_REPORT = 2'b10
    } ctl_t;

    typedef enum logic [2:0] {
        DET_A = 3'b000,
        DET_B = 3'b001,
        DET_C = 3'b010,
        DET_D = 3'b011,
        DET_E = 3'b100
    } det_t;

    ctl_t           ctl_q, ctl_d;
    det_t           det_q, det_d;
    logic [W-1:0]   data_q, data_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   zmask_q, zmask_d;
    logic [CW-1:0]  zcount_q, zcount_d;

    det_t           det_step;
    logic           z_step;

    // Detector transition table; the three unused encodings fall back to A
    // so a corrupted state heals on its next update.
    function automatic det_t det_next(input det_t s, input logic x);
        det_t n;
        case (s)
            DET_A:   n = x ? DET_B : DET_A;
            DET_B:   n = x ? DET_E : DET_B;
            DET_C:   n = x ? DET_B : DET_C;
            DET_D:   n = x ? DET_C : DET_B;
            DET_E:   n = x ? DET_E : DET_D;
            default: n = DET_A;
        endcase
        return n;
    endfunction

    always_comb begin
        ctl_d    = ctl_q;
        det_d    = det_q;
        data_d   = data_q;
        idx_d    = idx_q;
        zmask_d  = zmask_q;
        zcount_d = zcount_q;

        // Moore output of the state the detector moves into this cycle.
        det_step = det_next(det_q, data_q[idx_q]);
        z_step   = (det_step == DET_D) || (det_step == DET_E);

        case (ctl_q)
            CTL_IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    idx_d    = '0;
                    zmask_d  = '0;
                    zcount_d = '0;
                    if (in_clr) begin
                        det_d = DET_A;
                    end
                    ctl_d = CTL_SHIFT;
                end
            end
            CTL_SHIFT: begin
                det_d          = det_step;
                zmask_d[idx_q] = z_step;
                zcount_d       = zcount_q + CW'(z_step);
                if (idx_q == LAST_IDX) begin
                    ctl_d = CTL_REPORT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            CTL_REPORT: begin
                if (out_ready) begin
                    ctl_d = CTL_IDLE;
                end
            end
            default: begin
                ctl_d = CTL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q    <= CTL_IDLE;
            det_q    <= DET_A;
            data_q   <= '0;
            idx_q    <= '0;
            zmask_q  <= '0;
            zcount_q <= '0;
        end else begin
            ctl_q    <= ctl_d;
            det_q    <= det_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            zmask_q  <= zmask_d;
            zcount_q <= zcount_d;
        end
    end

    assign in_ready   = (ctl_q == CTL_IDLE);
    assign out_valid  = (ctl_q == CTL_REPORT);
    assign out_zmask  = zmask_q;
    assign out_zcount = zcount_q;
    assign fsm_state  = det_q;

endmodule

// File: tb/tb_fsm_byte_sched.sv
// ---------------------------------------------------------------------------
// tb_fsm_byte_sched
//
// Directed byte scenarios (reset, clear/chain, backpressure, mid-shift async
// reset) followed by a randomized run against a cycle-level reference of the
// handshake and a bit-serial reference of the detector. Expected results are
// queued when a byte is accepted and compared when the DUT reports it.
// ---------------------------------------------------------------------------
module tb_fsm_byte_sched;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_zmask;
    logic [CW-1:0] out_zcount;
    logic [2:0]    fsm_state;

    fsm_byte_sched #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_clr     (in_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_zmask  (out_zmask),
        .out_zcount (out_zcount),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  zmask;
        logic [CW-1:0] zcount;
        logic [2:0]    fstate;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference transition table of the detector.
    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic x);
        case (s)
            3'd0:    return x ? 3'd1 : 3'd0;
            3'd1:    return x ? 3'd4 : 3'd1;
            3'd2:    return x ? 3'd1 : 3'd2;
            3'd3:    return x ? 3'd2 : 3'd1;
            3'd4:    return x ? 3'd4 : 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    // Whole-byte result starting from detector state s0.
    function automatic exp_t ref_byte(input logic [2:0] s0, input logic [W-1:0] d);
        exp_t r;
        logic [2:0] s;
        s = s0;
        r.zmask  = '0;
        r.zcount = '0;
        for (int i = 0; i < W; i++) begin
            s = ref_next(s, d[i]);
            r.zmask[i] = (s == 3'd3) || (s == 3'd4);
            r.zcount   = r.zcount + CW'(r.zmask[i]);
        end
        r.fstate = s;
        return r;
    endfunction

    // Accept one byte, measure latency, check result, hold off the consumer
    // for 'hold' cycles while offering another byte, then complete.
    task automatic run_byte(input logic [W-1:0] d, input logic clr, input exp_t e, input int hold);
        exp_t got;
        int   n;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_clr    = clr;
        out_ready = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_clr   = 1'b0;
        n = 0;
        while (!out_valid && n < W + 4) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_edges", 32'(n), 32'(W));
        got = sb_q.pop_front();
        chk("zmask", 32'(out_zmask), 32'(got.zmask));
        chk("zcount", 32'(out_zcount), 32'(got.zcount));
        chk("fsm_state", 32'(fsm_state), 32'(got.fstate));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = ~d;
            in_clr   = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_zmask", 32'(out_zmask), 32'(got.zmask));
            chk("hold_zcount", 32'(out_zcount), 32'(got.zcount));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_clr    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_hs_valid", 32'(out_valid), 32'd0);
        chk("after_hs_ready", 32'(in_ready), 32'd1);
        $display("byte data=%02h clr=%0d zmask=%02h zcount=%0d state=%0d", d, clr, got.zmask, got.zcount, got.fstate);
    endtask

    initial begin
        logic [1:0]    m_st;
        logic [2:0]    m_det;
        logic [W-1:0]  m_data;
        int            m_idx;
        int            accepts;
        int            cycles;
        bit            seen_valid;
        exp_t          e;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_clr    = 1'b0;
        out_ready = 1'b0;

        // Reset is asynchronous: values must be there before any clock edge.
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_zmask", 32'(out_zmask), 32'd0);
        chk("rst_zcount", 32'(out_zcount), 32'd0);
        chk("rst_fsm_state", 32'(fsm_state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_byte(8'h00, 1'b1, exp_t'{8'h00, 4'd0, 3'd0}, 0);
        run_byte(8'h03, 1'b1, exp_t'{8'h06, 4'd2, 3'd1}, 0);
        run_byte(8'hFF, 1'b0, exp_t'{8'hFF, 4'd8, 3'd4}, 0);
        run_byte(8'h55, 1'b1, exp_t'{8'h0C, 4'd2, 3'd1}, 3);

        // Async reset in the middle of a byte (detector starts in B).
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_clr   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_fsm_state", 32'(fsm_state), 32'd4);
        chk("mid_zmask", 32'(out_zmask), 32'h0F);
        reset = 1'b1;
        #1;
        chk("mid_rst_zmask", 32'(out_zmask), 32'd0);
        chk("mid_rst_zcount", 32'(out_zcount), 32'd0);
        chk("mid_rst_fsm", 32'(fsm_state), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        #2;
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("discarded_no_valid", 32'(seen_valid), 32'd0);
        run_byte(8'h03, 1'b0, exp_t'{8'h06, 4'd2, 3'd1}, 0);

        // Randomized run with a cycle-level reference.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        sb_q.delete();
        m_st    = 2'd0;
        m_det   = 3'd0;
        m_data  = '0;
        m_idx   = 0;
        accepts = 0;
        cycles  = 0;
        while (accepts < 500 && cycles < 40000) begin
            @(negedge clk);
            cycles++;
            chk("rnd_in_ready", 32'(in_ready), 32'(m_st == 2'd0));
            chk("rnd_out_valid", 32'(out_valid), 32'(m_st == 2'd2));
            chk("rnd_fsm_state", 32'(fsm_state), 32'(m_det));
            if (m_st == 2'd2) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_sb_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("rnd_zmask", 32'(out_zmask), 32'(sb_q[0].zmask));
                    chk("rnd_zcount", 32'(out_zcount), 32'(sb_q[0].zcount));
                    chk("rnd_final_state", 32'(fsm_state), 32'(sb_q[0].fstate));
                end
            end
            if ($urandom_range(63) == 0) begin
                reset = 1'b1;
                #1;
                chk("rnd_rst_zmask", 32'(out_zmask), 32'd0);
                chk("rnd_rst_zcount", 32'(out_zcount), 32'd0);
                chk("rnd_rst_fsm", 32'(fsm_state), 32'd0);
                chk("rnd_rst_valid", 32'(out_valid), 32'd0);
                chk("rnd_rst_ready", 32'(in_ready), 32'd1);
                #1;
                reset = 1'b0;
                m_st  = 2'd0;
                m_det = 3'd0;
                sb_q.delete();
            end
            in_valid  = 1'($urandom_range(1));
            in_data   = W'($urandom);
            in_clr    = ($urandom_range(3) == 0);
            out_ready = 1'($urandom_range(1));
            @(posedge clk);
            case (m_st)
                2'd0: begin
                    if (in_valid) begin
                        if (in_clr) m_det = 3'd0;
                        sb_q.push_back(ref_byte(m_det, in_data));
                        m_data = in_data;
                        m_idx  = 0;
                        m_st   = 2'd1;
                        accepts++;
                    end
                end
                2'd1: begin
                    m_det = ref_next(m_det, m_data[m_idx]);
                    m_idx++;
                    if (m_idx == W) m_st = 2'd2;
                end
                default: begin
                    if (out_ready) begin
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            $display("rnd byte data=%02h zmask=%02h zcount=%0d state=%0d", m_data, e.zmask, e.zcount, e.fstate);
                        end
                        m_st = 2'd0;
                    end
                end
            endcase
        end
        chk("rnd_budget", 32'(accepts >= 500), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_byte_sched.md
FSM_BYTE_SCHED -- requirements
Module: fsm_byte_sched

Interface
REQ-001 SHALL have parameter W, default 8, meaning data byte width in bits (W >= 2).
REQ-002 SHALL have parameter CW, default $clog2(W+1), meaning the width of the z-count output.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the producer offers in_data.
REQ-006 SHALL have port in_ready  output  1  the block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  W  bit stream for the detector, applied LSB first.
REQ-008 SHALL have port in_clr  input  1  when high at accept, the detector starts from state A.
REQ-009 SHALL have port out_valid  output  1  a result is available.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port out_zmask  output  W  bit i = z after bit i is applied.
REQ-012 SHALL have port out_zcount  output  CW  number of ones in out_zmask.
REQ-013 SHALL have port fsm_state  output  3  current detector state encoding (debug).

Function
REQ-014 SHALL embed a Moore detector with 3-bit state encodings A=000, B=001, C=010, D=011, E=100; z=1 only in D and E.
REQ-015 SHALL use these detector transitions, written as x=0 / x=1: A->A/B; B->B/E; C->C/B; D->B/C; E->D/E.
REQ-016 SHALL recover any unused encoding (101, 110, 111) to A on the next detector update.
REQ-017 SHALL run a control FSM with states IDLE, SHIFT, REPORT; in_ready=1 exactly when the control FSM is in IDLE.
REQ-018 SHALL, on an IDLE cycle with in_valid=1, take the handshake: latch in_data, clear the bit index, clear the zmask/zcount accumulators, and go to SHIFT.
REQ-019 SHALL, if in_clr=1 at that accept, set the detector to A on the accept edge; otherwise the detector keeps its state across bytes.
REQ-020 SHALL, on each SHIFT cycle i (i = 0..W-1), apply x = latched bit i and advance the detector one transition.
REQ-021 SHALL, on the same SHIFT cycle, write z of the new state into zmask bit i and add it to zcount.
REQ-022 SHALL move from SHIFT to REPORT after bit W-1.
REQ-023 SHALL assert out_valid on cycle W+1 after the accept edge.
REQ-024 SHALL, in REPORT, hold out_valid=1 with stable out_zmask/out_zcount until out_ready=1, then return to IDLE on that edge.
REQ-025 SHALL NOT accept new input in REPORT or SHIFT; in_valid there is ignored with in_ready=0.
REQ-026 SHALL NOT advance the detector in IDLE or REPORT.
REQ-027 SHALL drive out_zmask and out_zcount as don't-care when out_valid=0 (they hold their last values).
REQ-028 SHALL make the minimum throughput interval W+2 cycles per byte when out_ready is held at 1.
REQ-029 SHALL have out_zcount saturate-free, since its maximum is W, which always fits in CW bits.

Reset
REQ-030 SHALL, while reset=1, force the control FSM to IDLE, the detector to A, out_valid=0, and out_zmask=0, out_zcount=0, fsm_state=000 immediately (without waiting for a clock edge).
REQ-031 SHALL hold in_ready=1 during and after reset.
REQ-032 SHALL, on reset in SHIFT or REPORT, discard the in-flight byte and never present its result.

Verification
REQ-033 SHALL cover: W=8, reset, accept 0x00 with in_clr=1 -> out_valid at accept+9, zmask=0x00, zcount=0, fsm_state=000.
REQ-034 SHALL cover: accept 0x03 with in_clr=1 -> zmask=0x06, zcount=2, final fsm_state=001.
REQ-035 SHALL cover: next accept 0xFF with in_clr=0 (chained from B) -> zmask=0xFF, zcount=8, fsm_state=100.
REQ-036 SHALL cover: accept 0x55 with in_clr=1 -> zmask=0x0C, zcount=2, fsm_state=001.
REQ-037 SHALL cover backpressure: out_ready=0 for 3 cycles in REPORT -> out_valid and data stable, in_ready=0 throughout, and the next accept occurs only after the out_ready handshake.
REQ-038 SHALL cover async reset pulse mid-SHIFT (after bit 3) -> outputs cleared immediately, no out_valid for that byte, and the next byte behaves as in_clr=1.
REQ-039 SHALL cover random stimulus against a bit-serial reference model of REQ-015 for 500 bytes (reset on ~1/64 cycles), checked every cycle.
